// File: rtl/timer_pkg.sv
// Shared definitions for the seconds/minutes/hours timer chain.
package timer_pkg;

    localparam int SEC_PER_MIN = 60;
    localparam int TIME_W      = 6;

    typedef logic [TIME_W-1:0] time6_t;

    // Out-of-range preset values collapse to zero rather than wrapping.
    function automatic time6_t clamp_second(input time6_t value);
        return (value < time6_t'(SEC_PER_MIN)) ? value : '0;
    endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Free-running divider: counts 0..CLK_FREQ_HZ-1 while run=1, pulses tc on the wrap cycle.
module clk_prescaler #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int PRESC_W     = $clog2(CLK_FREQ_HZ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               clear,
    output logic               tc,
    output logic [PRESC_W-1:0] count
);

    localparam logic [PRESC_W-1:0] TERMINAL = PRESC_W'(CLK_FREQ_HZ - 1);

    // tc is gated by run so a pause landing on the terminal count never emits a pulse.
    assign tc = run && !clear && (count == TERMINAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/second_counter.sv
// Seconds stage of the timer chain: 1 Hz tick, 0..59 counter, carry into the minute stage.
// Optional half-second blink output is enabled by defining SECOND_BLINK_EN.
module second_counter
    import timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int PRESC_W     = $clog2(CLK_FREQ_HZ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              set,
    input  logic [TIME_W-1:0] set_second,
    output logic [TIME_W-1:0] r_second,
    output logic              tick_1hz,
    output logic              carry_for_min,
    output logic              blink
);

    localparam time6_t LAST_SECOND = time6_t'(SEC_PER_MIN - 1);

    logic               presc_tc;
    logic [PRESC_W-1:0] presc_count;

    clk_prescaler #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .PRESC_W     (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (set),
        .tc    (presc_tc),
        .count (presc_count)
    );

    // tick_1hz and carry_for_min are single-cycle flop pulses; set overrides any pending tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_second      <= '0;
            tick_1hz      <= 1'b0;
            carry_for_min <= 1'b0;
        end else if (set) begin
            r_second      <= clamp_second(set_second);
            tick_1hz      <= 1'b0;
            carry_for_min <= 1'b0;
        end else begin
            tick_1hz      <= presc_tc;
            carry_for_min <= 1'b0;
            if (presc_tc) begin
                if (r_second == LAST_SECOND) begin
                    r_second      <= '0;
                    carry_for_min <= 1'b1;
                end else begin
                    r_second <= r_second + 1'b1;
                end
            end
        end
    end

`ifdef SECOND_BLINK_EN
    localparam logic [PRESC_W-1:0] HALF_COUNT = PRESC_W'(CLK_FREQ_HZ / 2);

    logic blink_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_q <= 1'b0;
        end else if (set) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= run && (presc_count < HALF_COUNT);
        end
    end

    assign blink = blink_q;
`else
    logic unused_presc_count;
    assign unused_presc_count = ^presc_count;
    assign blink              = 1'b0;
`endif

endmodule

// File: tb/tb_second_counter.sv
// Directed bench for second_counter at CLK_FREQ_HZ=4; tick events are checked via an expected queue.
module tb_second_counter;

    localparam int HZ = 4;

    logic       clk;
    logic       reset;
    logic       run;
    logic       set;
    logic [5:0] set_second;
    logic [5:0] r_second;
    logic       tick_1hz;
    logic       carry_for_min;
    logic       blink;

    int errors = 0;
    int checks = 0;

    // Each entry is {carry_for_min, r_second} expected on the next tick_1hz pulse.
    logic [6:0] exp_q[$];

    second_counter #(
        .CLK_FREQ_HZ (HZ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .set           (set),
        .set_second    (set_second),
        .r_second      (r_second),
        .tick_1hz      (tick_1hz),
        .carry_for_min (carry_for_min),
        .blink         (blink)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every tick pulse is matched against the expected queue
    always @(negedge clk) begin
        if (tick_1hz === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: got r_second=%0d carry=%0d expected no tick at %0t",
                         r_second, carry_for_min, $time);
            end else begin
                check("tick_event", {carry_for_min, r_second}, exp_q.pop_front());
            end
        end else if (carry_for_min !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL carry_without_tick: got carry=%0d expected 0 at %0t", carry_for_min, $time);
        end
    end

    // Driver: all inputs change on the falling edge
    initial begin
        logic [3:0] blink_pat;
        blink_pat  = 4'b0011;
        reset      = 1'b1;
        run        = 1'b0;
        set        = 1'b0;
        set_second = '0;
        wait_neg(3);
        reset = 1'b0;
        check("reset_r_second", 7'(r_second), 7'd0);
        check("reset_tick", 7'(tick_1hz), 7'd0);
        check("reset_carry", 7'(carry_for_min), 7'd0);
        check("reset_blink", 7'(blink), 7'd0);

        // Free run: ticks every 4 clk, blink pattern 1,1,0,0
        exp_q.push_back({1'b0, 6'd1});
        exp_q.push_back({1'b0, 6'd2});
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_neg(1);
`ifdef SECOND_BLINK_EN
            check("blink_pattern", 7'(blink), 7'(blink_pat[i % 4]));
`else
            check("blink_off", 7'(blink), 7'd0);
`endif
        end

        // Preset 58, then wrap through 59 -> 0 with carry
        exp_q.push_back({1'b0, 6'd59});
        exp_q.push_back({1'b1, 6'd0});
        set        = 1'b1;
        set_second = 6'd58;
        wait_neg(1);
        set = 1'b0;
        check("preset_58", 7'(r_second), 7'd58);
        wait_neg(4);
        check("reach_59", 7'(r_second), 7'd59);
        wait_neg(4);
        check("wrap_r_second", 7'(r_second), 7'd0);
        check("wrap_carry", 7'(carry_for_min), 7'd1);
        check("wrap_tick", 7'(tick_1hz), 7'd1);
        wait_neg(1);
        check("carry_one_clk", 7'(carry_for_min), 7'd0);
        check("tick_one_clk", 7'(tick_1hz), 7'd0);

        // Presets: in-range value loads, out-of-range value clamps to 0
        set        = 1'b1;
        set_second = 6'd30;
        wait_neg(1);
        check("preset_30", 7'(r_second), 7'd30);
        set_second = 6'd63;
        wait_neg(1);
        check("preset_63", 7'(r_second), 7'd0);
        check("preset_63_tick", 7'(tick_1hz), 7'd0);
        check("preset_63_carry", 7'(carry_for_min), 7'd0);
        set = 1'b0;
        run = 1'b0;

        // Pause keeps the prescaler residue
        exp_q.push_back({1'b0, 6'd1});
        run = 1'b1;
        wait_neg(2);
        run = 1'b0;
        wait_neg(10);
        check("pause_hold", 7'(r_second), 7'd0);
        run = 1'b1;
        wait_neg(1);
        check("resume_no_tick_yet", 7'(tick_1hz), 7'd0);
        wait_neg(1);
        check("resume_tick", 7'(tick_1hz), 7'd1);
        check("resume_r_second", 7'(r_second), 7'd1);
        run = 1'b0;

        // Async reset in the tc cycle at 59 suppresses the carry
        set        = 1'b1;
        set_second = 6'd59;
        wait_neg(1);
        set = 1'b0;
        run = 1'b1;
        wait_neg(3);
        check("pre_reset_59", 7'(r_second), 7'd59);
        #2;
        reset = 1'b1;
        #1;
        check("async_r_second", 7'(r_second), 7'd0);
        check("async_tick", 7'(tick_1hz), 7'd0);
        check("async_carry", 7'(carry_for_min), 7'd0);
        wait_neg(2);
        reset = 1'b0;
        run   = 1'b0;
        wait_neg(3);
        check("post_reset_r_second", 7'(r_second), 7'd0);

        check("exp_q_drained", 7'(exp_q.size()), 7'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
